fault_dict_sequencer: RTL and testbench



---
 rtl/fault_dict_sequencer.sv | 149 ++++++++++++++
 tb/tb_fault_dict_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fault_dict_sequencer.sv
// Fault-dictionary sequencer: for each collapsed fault it applies every stored pattern
// to the good and faulty circuits and emits one syndrome entry per fault.
module fault_dict_sequencer #(
    parameter int IN_W    = 50,
    parameter int OUT_W   = 22,
    parameter int NUM_PAT = 148,
    parameter int NUM_FLT = 2230,
    parameter int SETTLE  = 2,
    localparam int PAT_AW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int FLT_AW = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1,
    localparam int CNT_W  = $clog2(NUM_FLT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [PAT_AW-1:0]  pat_addr,
    input  logic [IN_W-1:0]    pat_rdata,
    output logic [FLT_AW-1:0]  flt_sel,
    output logic               inj_en,
    output logic [IN_W-1:0]    vec,
    input  logic [OUT_W-1:0]   good_out,
    input  logic [OUT_W-1:0]   faulty_out,
    output logic               dct_valid,
    input  logic               dct_ready,
    output logic [FLT_AW-1:0]  dct_fault,
    output logic [NUM_PAT-1:0] dct_syndrome,
    output logic               dct_detected,
    output logic [CNT_W-1:0]   det_count
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INJECT  = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_RDWAIT  = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_EMIT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [FLT_AW-1:0]  flt_idx_q, flt_idx_d;
    logic [PAT_AW-1:0]  pat_idx_q, pat_idx_d;
    logic [PAT_AW-1:0]  pat_addr_q, pat_addr_d;
    logic [NUM_PAT-1:0] syn_q, syn_d;
    logic [IN_W-1:0]    vec_q, vec_d;
    logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;

    always_comb begin
        state_d    = state_q;
        flt_idx_d  = flt_idx_q;
        pat_idx_d  = pat_idx_q;
        pat_addr_d = pat_addr_q;
        syn_d      = syn_q;
        vec_d      = vec_q;
        det_cnt_d  = det_cnt_q;
        set_cnt_d  = set_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    det_cnt_d = '0;
                    flt_idx_d = '0;
                    pat_idx_d = '0;
                    syn_d     = '0;
                    state_d   = S_INJECT;
                end
            end
            S_INJECT: begin
                // Address is registered on entry so it is already valid throughout FETCH.
                pat_addr_d = pat_idx_q;
                state_d    = S_FETCH;
            end
            S_FETCH:  state_d = S_RDWAIT;
            S_RDWAIT: begin
                vec_d     = pat_rdata;
                set_cnt_d = '0;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (set_cnt_q == SET_W'(SETTLE - 1)) state_d = S_COMPARE;
                else set_cnt_d = set_cnt_q + 1'b1;
            end
            S_COMPARE: begin
                syn_d[pat_idx_q] = (good_out != faulty_out);
                if (pat_idx_q == PAT_AW'(NUM_PAT - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    pat_idx_d  = pat_idx_q + 1'b1;
                    pat_addr_d = pat_idx_q + 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EMIT: begin
                if (dct_ready) begin
                    det_cnt_d = det_cnt_q + CNT_W'(|syn_q);
                    if (flt_idx_q == FLT_AW'(NUM_FLT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        flt_idx_d = flt_idx_q + 1'b1;
                        pat_idx_d = '0;
                        syn_d     = '0;
                        state_d   = S_INJECT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            flt_idx_q  <= '0;
            pat_idx_q  <= '0;
            pat_addr_q <= '0;
            syn_q      <= '0;
            vec_q      <= '0;
            det_cnt_q  <= '0;
            set_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            flt_idx_q  <= flt_idx_d;
            pat_idx_q  <= pat_idx_d;
            pat_addr_q <= pat_addr_d;
            syn_q      <= syn_d;
            vec_q      <= vec_d;
            det_cnt_q  <= det_cnt_d;
            set_cnt_q  <= set_cnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign inj_en       = (state_q >= S_INJECT) && (state_q <= S_COMPARE);
    assign dct_valid    = (state_q == S_EMIT);
    assign pat_addr     = pat_addr_q;
    assign flt_sel      = flt_idx_q;
    assign vec          = vec_q;
    assign dct_fault    = flt_idx_q;
    assign dct_syndrome = syn_q;
    assign dct_detected = |syn_q;
    assign det_count    = det_cnt_q;

endmodule

// File: tb/tb_fault_dict_sequencer.sv
// Directed bench: small dictionary run (4 patterns, 3 faults) with a table of
// per-fault detection masks and hand-computed entries, plus multi-cycle corner cases.
module tb_fault_dict_sequencer;

    localparam int IN_W = 8, OUT_W = 4, NUM_PAT = 4, NUM_FLT = 3, SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst, start, dct_ready;
    logic       busy, done, inj_en, dct_valid, dct_detected;
    logic [1:0] pat_addr, flt_sel, dct_fault, det_count;
    logic [7:0] pat_rdata, vec;
    logic [3:0] good_out, faulty_out, dct_syndrome;

    fault_dict_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(NUM_PAT),
                           .NUM_FLT(NUM_FLT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pat_addr(pat_addr), .pat_rdata(pat_rdata), .flt_sel(flt_sel), .inj_en(inj_en),
        .vec(vec), .good_out(good_out), .faulty_out(faulty_out),
        .dct_valid(dct_valid), .dct_ready(dct_ready), .dct_fault(dct_fault),
        .dct_syndrome(dct_syndrome), .dct_detected(dct_detected), .det_count(det_count)
    );

    always #5 clk = ~clk;

    // Per fault: input = pattern mask where the faulty circuit diverges; expected entry fields.
    typedef struct {
        logic [3:0] diff_mask;
        logic [1:0] exp_fault;
        logic [3:0] exp_syn;
        logic       exp_det;
    } vec_t;
    vec_t tab [NUM_FLT];

    // Pattern memory with one-cycle read latency; pattern i holds 8'hA0+i.
    always @(posedge clk) pat_rdata <= 8'hA0 + {6'd0, pat_addr};

    logic [3:0] cur_mask;
    logic       diverge;
    always_comb begin
        cur_mask = tab[flt_sel].diff_mask;
        diverge  = inj_en && cur_mask[vec[1:0]];
    end
    assign good_out   = vec[3:0] ^ 4'h5;
    assign faulty_out = good_out ^ {3'b000, diverge};

    logic [1:0] cap_f[$];
    logic [3:0] cap_s[$];
    logic       cap_d[$];
    always @(negedge clk) if (dct_valid && dct_ready) begin
        cap_f.push_back(dct_fault);
        cap_s.push_back(dct_syndrome);
        cap_d.push_back(dct_detected);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_entries(input string tag);
        chk({tag, " entry_count"}, cap_f.size(), NUM_FLT);
        for (int i = 0; i < NUM_FLT && i < cap_f.size(); i++) begin
            chk({tag, " fault"},    cap_f[i], tab[i].exp_fault);
            chk({tag, " syndrome"}, cap_s[i], tab[i].exp_syn);
            chk({tag, " detected"}, cap_d[i], tab[i].exp_det);
        end
        chk({tag, " det_count"}, det_count, 2);
    endtask

    // mode 0 plain, 1 backpressure at fault 1, 2 start pulse during fault 1, 3 reset mid-run
    task automatic run(input int mode, output int done_cyc);
        int stall = 0, bpv = 0;
        bit pulsed = 0;
        logic [3:0] s0;
        logic [1:0] pa0, dc0;
        step(); step();
        cap_f.delete(); cap_s.delete(); cap_d.delete();
        done_cyc = -1;
        start = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            step();
            start = 1'b0;
            dct_ready = 1'b1;
            if (n == 1) chk("busy_after_start", busy, 1);
            if (mode == 2 && !pulsed && inj_en && flt_sel == 2'd1) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (mode == 1 && dct_valid && dct_fault == 2'd1) begin
                if (bpv == 0) begin
                    s0 = dct_syndrome; pa0 = pat_addr; dc0 = det_count;
                end else begin
                    chk("bp_syndrome_hold", dct_syndrome, s0);
                    chk("bp_pat_addr_hold", pat_addr, pa0);
                    chk("bp_det_count_hold", det_count, dc0);
                end
                bpv++;
                if (stall < 5) begin
                    dct_ready = 1'b0;
                    stall++;
                end
            end
            if (mode == 3 && inj_en && flt_sel == 2'd1 && pat_addr == 2'd2 && vec == 8'hA2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("midrst_inj_en", inj_en, 0);
                chk("midrst_det_count", det_count, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_dct_valid", dct_valid, 0);
                chk("midrst_vec", vec, 0);
                chk("midrst_pat_addr", pat_addr, 0);
                chk("midrst_flt_sel", flt_sel, 0);
                done_cyc = -2;
                return;
            end
            if (done) begin
                done_cyc = n;
                chk("busy_at_done", busy, 0);
                break;
            end
        end
        if (mode == 1) chk("bp_valid_cycles", bpv, 6);
        if (done_cyc == -1) chk("run_timeout", 0, 1);
    endtask

    int dc;

    initial begin
        tab[0] = '{diff_mask: 4'b0000, exp_fault: 2'd0, exp_syn: 4'b0000, exp_det: 1'b0};
        tab[1] = '{diff_mask: 4'b0100, exp_fault: 2'd1, exp_syn: 4'b0100, exp_det: 1'b1};
        tab[2] = '{diff_mask: 4'b1111, exp_fault: 2'd2, exp_syn: 4'b1111, exp_det: 1'b1};

        rst = 1'b1; start = 1'b1; dct_ready = 1'b1;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pat_addr", pat_addr, 0);
        chk("rst_flt_sel", flt_sel, 0);
        chk("rst_inj_en", inj_en, 0);
        chk("rst_vec", vec, 0);
        chk("rst_dct_valid", dct_valid, 0);
        chk("rst_dct_fault", dct_fault, 0);
        chk("rst_dct_syndrome", dct_syndrome, 0);
        chk("rst_dct_detected", dct_detected, 0);
        chk("rst_det_count", det_count, 0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("idle_after_rst_busy", busy, 0);

        run(0, dc);
        chk("plain_done_cycle", dc, 67);
        chk_entries("plain");
        step(); step(); step();
        chk("hold_busy", busy, 0);
        chk("hold_done", done, 0);
        chk("hold_det_count", det_count, 2);
        chk("hold_pat_addr", pat_addr, 3);
        chk("hold_vec", vec, 8'hA3);
        chk("hold_inj_en", inj_en, 0);
        chk("hold_dct_valid", dct_valid, 0);

        run(1, dc);
        chk("bp_done_cycle", dc, 72);
        chk_entries("bp");

        run(2, dc);
        chk("startbusy_done_cycle", dc, 67);
        chk_entries("startbusy");

        run(3, dc);
        chk("midrst_aborted", dc, -2);
        run(0, dc);
        chk("rerun_done_cycle", dc, 67);
        chk_entries("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
